// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between two requesters: port 0 (instruction
// fetch) and port 1 (data load/store). Requests are arbitrated round-robin.
// Only one memory transaction is outstanding at a time. A timeout counter
// retires a hung transaction with an error response.
//
// Handshake semantics:
//   - A request transfers on the cycle where reqN_valid && reqN_ready are
//     both high. The requester holds its valid, write, addr and wdata stable
//     until then. reqN_ready is combinational and is only ever high in IDLE,
//     and only for the granted port.
//   - The memory request transfers on the cycle where mem_valid && mem_ready
//     are both high. mem_write, mem_addr and mem_wdata are held stable while
//     mem_valid is high.
//   - mem_resp_valid completes the transaction. It is honoured only in WAIT.
//   - respN_valid is a single-cycle pulse with no back-pressure. resp_rdata
//     and resp_error are meaningful only while a resp pulse is high.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-low reset
//   req0_*                fetch requester (valid/write/addr/wdata in, ready out)
//   resp0_valid           fetch response pulse
//   req1_*, resp1_valid   data requester, same shape as port 0
//   resp_rdata            read data for the pulsing port (0 for writes/timeouts)
//   resp_error            response was produced by a timeout
//   mem_*                 memory request channel and completion inputs
//   error_sticky          set by any timeout, cleared only by reset
//   busy                  a transaction is in progress (state != IDLE)
//   state_dbg             current FSM state, for observation
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  resp0_valid,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  resp1_valid,

    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  error_sticky,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic                     last_grant;
    logic                     lat_port;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

    logic                     grant_en;
    logic                     grant_port;
    logic                     complete;
    logic                     timed_out;
    logic                     tmo_hit;

    // The counter holds the number of cycles already spent in ISSUE/WAIT
    // before the current one, so hitting TIMEOUT means this is the last
    // cycle a completion can still win.
    assign tmo_hit = (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state, grant decision and transaction events
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_en   = 1'b0;
        grant_port = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the port that did not win last time is served.
                if (req0_valid && req1_valid) begin
                    grant_en   = 1'b1;
                    grant_port = ~last_grant;
                end else if (req0_valid) begin
                    grant_en   = 1'b1;
                    grant_port = 1'b0;
                end else if (req1_valid) begin
                    grant_en   = 1'b1;
                    grant_port = 1'b1;
                end
                req0_ready = grant_en && !grant_port;
                req1_ready = grant_en &&  grant_port;
                if (grant_en) begin
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                // A timeout abandons the request even if memory accepts now.
                if (tmo_hit) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end else if (mem_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                // A completion on the timeout cycle still counts as success.
                if (mem_resp_valid) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_valid = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Request latch, round-robin history and timeout counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (grant_en) begin
                last_grant <= grant_port;
                lat_port   <= grant_port;
                mem_write  <= grant_port ? req1_write : req0_write;
                mem_addr   <= grant_port ? req1_addr  : req0_addr;
                mem_wdata  <= grant_port ? req1_wdata : req0_wdata;
                tmo_cnt    <= '0;
            end else if ((state != IDLE) && (state_next != IDLE)) begin
                // Stops counting on retire so the counter never wraps.
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response pulse, read data and sticky error
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp0_valid  <= 1'b0;
            resp1_valid  <= 1'b0;
            resp_error   <= 1'b0;
            resp_rdata   <= '0;
            error_sticky <= 1'b0;
        end else begin
            resp0_valid <= (complete || timed_out) && !lat_port;
            resp1_valid <= (complete || timed_out) &&  lat_port;
            resp_error  <= timed_out;
            if (complete) begin
                // Writes carry no read data; whatever is on the bus is dropped.
                resp_rdata <= mem_write ? '0 : mem_rdata;
            end else if (timed_out) begin
                resp_rdata <= '0;
            end
            if (timed_out) begin
                error_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int TW  = 8;
    localparam int QW  = DW + 2;

    // -----------------------------------------------------------------------
    // DUT signals
    // -----------------------------------------------------------------------
    logic          clock;
    logic          reset;
    logic          req0_valid, req0_write, req0_ready, resp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_write, req1_ready, resp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          mem_valid, mem_write, mem_ready, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          error_sticky, busy;
    logic [1:0]    state_dbg;

    mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (TMO),
        .TIMEOUT_WIDTH(TW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_write    (req0_write),
        .req0_addr     (req0_addr),
        .req0_wdata    (req0_wdata),
        .req0_ready    (req0_ready),
        .resp0_valid   (resp0_valid),
        .req1_valid    (req1_valid),
        .req1_write    (req1_write),
        .req1_addr     (req1_addr),
        .req1_wdata    (req1_wdata),
        .req1_ready    (req1_ready),
        .resp1_valid   (resp1_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_valid     (mem_valid),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata),
        .error_sticky  (error_sticky),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // -----------------------------------------------------------------------
    // Bench state: counters, requesters, memory contents, reference model
    // -----------------------------------------------------------------------
    int n_cmp;
    int n_err;

    // Pending request per port (held until the model says it was granted).
    logic          rv [2];
    logic          rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];

    // Stimulus knobs.
    int unsigned   auto_pct;
    logic          tmpl_en;
    logic [AW-1:0] tmpl_a [2];
    logic          spur_en;
    int            fix_d1;
    int            fix_d2;

    logic [DW-1:0] mem_model [16];

    // Transaction-level reference: one outstanding transaction, its age in
    // busy cycles, whether memory has taken it, and planned memory delays.
    logic          m_busy;
    logic          m_acc;
    int            m_port;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    int            m_age;
    int            m_d1;
    int            m_d2;
    int            m_last;
    logic          sticky;

    // Scoreboard: {error, port, rdata} of the response due next cycle.
    logic [QW-1:0] exp_q [$];

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rv[p] = 1'b1;
        rw[p] = w;
        ra[p] = a;
        rd[p] = d;
    endtask

    task automatic drive_idle();
        req0_valid     = 1'b0;
        req0_write     = 1'b0;
        req0_addr      = '0;
        req0_wdata     = '0;
        req1_valid     = 1'b0;
        req1_write     = 1'b0;
        req1_addr      = '0;
        req1_wdata     = '0;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_acc  = 1'b0;
        m_port = 0;
        m_age  = 0;
        m_last = 1;
        sticky = 1'b0;
        rv[0]  = 1'b0;
        rv[1]  = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req0_ready"},   64'(req0_ready),   64'(0));
        chk({tag, "_req1_ready"},   64'(req1_ready),   64'(0));
        chk({tag, "_resp0_valid"},  64'(resp0_valid),  64'(0));
        chk({tag, "_resp1_valid"},  64'(resp1_valid),  64'(0));
        chk({tag, "_resp_error"},   64'(resp_error),   64'(0));
        chk({tag, "_resp_rdata"},   64'(resp_rdata),   64'(0));
        chk({tag, "_mem_valid"},    64'(mem_valid),    64'(0));
        chk({tag, "_mem_write"},    64'(mem_write),    64'(0));
        chk({tag, "_mem_addr"},     64'(mem_addr),     64'(0));
        chk({tag, "_mem_wdata"},    64'(mem_wdata),    64'(0));
        chk({tag, "_error_sticky"}, 64'(error_sticky), 64'(0));
        chk({tag, "_busy"},         64'(busy),         64'(0));
    endtask

    // Holds reset for a cycle, checks every output is zero, releases it.
    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clock);
        chk_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // One clock cycle: drive requesters and memory, predict and compare at
    // the falling edge, then advance the reference model.
    task automatic run_cycle();
        int            g;
        logic          idle;
        logic          mrdy;
        logic          mrsp;
        logic [DW-1:0] mrd;
        logic [DW-1:0] rdv;
        logic [QW-1:0] e;

        for (int p = 0; p < 2; p++) begin
            if (!rv[p] && auto_pct != 0 && $urandom_range(99) < auto_pct) begin
                if (tmpl_en) begin
                    post_req(p, 1'b0, tmpl_a[p], '0);
                end else begin
                    post_req(p, ($urandom_range(4) == 0),
                             {26'd0, 4'($urandom_range(15)), 2'b00}, $urandom);
                end
            end
        end

        mrdy = 1'b0;
        mrsp = 1'b0;
        mrd  = $urandom;
        if (m_busy && !m_acc) begin
            mrdy = (m_d1 == 0);
        end else if (spur_en) begin
            mrdy = 1'($urandom_range(1));
        end
        if (m_busy && m_acc) begin
            mrsp = (m_d2 == 0);
        end else if (spur_en) begin
            mrsp = ($urandom_range(3) == 0);
        end
        if (m_busy && m_acc && mrsp && !m_wr) begin
            mrd = mem_model[m_addr[5:2]];
        end

        req0_valid     = rv[0];
        req0_write     = rw[0];
        req0_addr      = ra[0];
        req0_wdata     = rd[0];
        req1_valid     = rv[1];
        req1_write     = rw[1];
        req1_addr      = ra[1];
        req1_wdata     = rd[1];
        mem_ready      = mrdy;
        mem_resp_valid = mrsp;
        mem_rdata      = mrd;

        idle = !m_busy;
        g    = -1;
        if (idle) begin
            if (rv[0] && rv[1]) g = 1 - m_last;
            else if (rv[0])     g = 0;
            else if (rv[1])     g = 1;
        end

        @(negedge clock);
        chk("req0_ready",   64'(req0_ready),   64'(idle && g == 0));
        chk("req1_ready",   64'(req1_ready),   64'(idle && g == 1));
        chk("busy",         64'(busy),         64'(m_busy));
        chk("mem_valid",    64'(mem_valid),    64'(m_busy && !m_acc));
        chk("error_sticky", 64'(error_sticky), 64'(sticky));
        if (m_busy && !m_acc) begin
            chk("mem_addr",  64'(mem_addr),  64'(m_addr));
            chk("mem_write", 64'(mem_write), 64'(m_wr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wd));
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp0_valid", 64'(resp0_valid), 64'(e[DW] == 1'b0));
            chk("resp1_valid", 64'(resp1_valid), 64'(e[DW] == 1'b1));
            chk("resp_error",  64'(resp_error),  64'(e[QW-1]));
            chk("resp_rdata",  64'(resp_rdata),  64'(e[DW-1:0]));
        end else begin
            chk("resp0_idle", 64'(resp0_valid), 64'(0));
            chk("resp1_idle", 64'(resp1_valid), 64'(0));
        end

        if (idle) begin
            if (g >= 0) begin
                m_busy = 1'b1;
                m_acc  = 1'b0;
                m_port = g;
                m_wr   = rw[g];
                m_addr = ra[g];
                m_wd   = rd[g];
                m_age  = 0;
                m_d1   = (fix_d1 >= 0) ? fix_d1 : int'($urandom_range(2));
                m_last = g;
                rv[g]  = 1'b0;
            end
        end else if (m_acc && mrsp) begin
            rdv = m_wr ? '0 : mem_model[m_addr[5:2]];
            if (m_wr) mem_model[m_addr[5:2]] = m_wd;
            exp_q.push_back({1'b0, 1'(m_port), rdv});
            m_busy = 1'b0;
        end else if (m_age == TMO) begin
            exp_q.push_back({1'b1, 1'(m_port), {DW{1'b0}}});
            sticky = 1'b1;
            m_busy = 1'b0;
        end else begin
            if (!m_acc) begin
                if (mrdy) begin
                    m_acc = 1'b1;
                    m_d2  = (fix_d2 >= 0) ? fix_d2 : int'($urandom_range(3));
                end else begin
                    m_d1--;
                end
            end else begin
                m_d2--;
            end
            m_age++;
        end

        @(posedge clock);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed steps followed by a randomized run
    // -----------------------------------------------------------------------
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        auto_pct = 0;
        tmpl_en  = 1'b0;
        tmpl_a[0] = 32'h100;
        tmpl_a[1] = 32'h200;
        spur_en  = 1'b0;
        fix_d1   = 0;
        fix_d2   = 0;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        for (int p = 0; p < 2; p++) begin
            rw[p] = 1'b0;
            ra[p] = '0;
            rd[p] = '0;
        end
        do_reset();

        // Single read on port 0 with the fastest memory.
        mem_model[4] = 32'hDEADBEEF;
        post_req(0, 1'b0, 32'h10, '0);
        repeat (5) run_cycle();

        // Both ports requesting continuously right after reset.
        do_reset();
        tmpl_en  = 1'b1;
        auto_pct = 100;
        repeat (16) run_cycle();
        auto_pct = 0;
        tmpl_en  = 1'b0;
        repeat (4) run_cycle();

        // Port 1 write with memory stalling acceptance for three cycles.
        fix_d1 = 3;
        post_req(1, 1'b1, 32'h40, 32'h12345678);
        repeat (8) run_cycle();

        // Port 0 request arriving on the cycle the port 1 response pulses.
        fix_d1 = 0;
        post_req(1, 1'b0, 32'h44, '0);
        repeat (3) run_cycle();
        post_req(0, 1'b0, 32'h48, '0);
        repeat (5) run_cycle();

        // Memory accepts but never completes; then a normal request.
        fix_d2 = 1000;
        post_req(1, 1'b0, 32'h80, '0);
        repeat (8) run_cycle();
        fix_d2 = 0;
        post_req(0, 1'b0, 32'h84, '0);
        repeat (5) run_cycle();

        // Reset while waiting for memory, then a late completion.
        fix_d2 = 1000;
        post_req(0, 1'b0, 32'h20, 32'h0);
        run_cycle();
        run_cycle();
        reset = 1'b0;
        drive_idle();
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clock);
        #1;
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = $urandom;
        @(negedge clock);
        chk("late_busy", 64'(busy), 64'(0));
        @(posedge clock);
        #1;
        mem_resp_valid = 1'b0;
        @(negedge clock);
        chk("late_resp0", 64'(resp0_valid), 64'(0));
        chk("late_resp1", 64'(resp1_valid), 64'(0));
        chk("late_busy2", 64'(busy),        64'(0));
        @(posedge clock);
        #1;
        model_reset();

        // Randomized traffic, memory delays and stray memory strobes.
        fix_d1   = -1;
        fix_d2   = -1;
        spur_en  = 1'b1;
        auto_pct = 40;
        repeat (1500) run_cycle();

        auto_pct = 0;
        spur_en  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!(m_busy || exp_q.size() != 0 || rv[0] || rv[1])) break;
            run_cycle();
        end
        chk("drain", 64'(m_busy || exp_q.size() != 0 || rv[0] || rv[1]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported instruction/data memory between two requesters: port 0 (instruction fetch, driven from the cpu PC) and port 1 (data load/store, driven from cpu ALU_result/write_data/mem_write). It arbitrates round-robin and keeps one transaction outstanding at a time. Each transaction follows a valid/ready request, then a response pulse. A timeout counter retires hung memory transactions with an error. It sits between the cpu and the memory model, and its response pulses drive the cpu step/stall sequencing.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT, 255, max cycles in ISSUE+WAIT before forced retire; legal range 2..2^TIMEOUT_WIDTH-1
TIMEOUT_WIDTH, 8, timeout counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  fetch request valid
req0_write  input  1  fetch write enable (normally 0)
req0_addr  input  ADDR_WIDTH  fetch address
req0_wdata  input  DATA_WIDTH  fetch write data
req0_ready  output  1  fetch request accepted this cycle
resp0_valid  output  1  one-cycle response pulse, port 0
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, resp1_valid  as port 0, for the data port
resp_rdata  output  DATA_WIDTH  read data for whichever resp*_valid is high
resp_error  output  1  qualifies resp*_valid; response was a timeout
mem_valid  output  1  memory request valid
mem_write  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_ready  input  1  memory accepts request
mem_resp_valid  input  1  memory completion (reads and writes)
mem_rdata  input  DATA_WIDTH  memory read data
error_sticky  output  1  set on any timeout; cleared only by reset
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, last_grant=1 (port 0 wins the first tie), timeout counter=0. All outputs are 0, including latched mem_addr/mem_wdata/resp_rdata.
- States: IDLE, ISSUE, WAIT.
- IDLE: req*_ready is combinational. Grant rules:
  - Only one req*_valid high: grant that port.
  - Both high: grant the port != last_grant.
  - reqN_ready=1 only for the granted port, only in IDLE; handshake completes on valid&&ready.
  - On grant: latch write/addr/wdata, set last_grant=N, clear counter, go to ISSUE.
  - No valid: stay in IDLE; all ready signals 0.
- ISSUE: mem_valid=1 with latched fields, held stable until mem_ready. On mem_valid&&mem_ready, go to WAIT.
- WAIT: mem_valid=0. On mem_resp_valid:
  - Register mem_rdata into resp_rdata (forced 0 for writes).
  - Pulse respN_valid for the granted port exactly one cycle later, with resp_error=0.
  - Go to IDLE.
  - A new request may be granted in the same cycle the response pulse is high.
- mem_resp_valid while in IDLE or ISSUE is ignored.
- Timeout: counter increments every cycle in ISSUE or WAIT. If it reaches TIMEOUT with no completion:
  - Next cycle: respN_valid=1, resp_error=1, resp_rdata=0, error_sticky=1.
  - State goes to IDLE; mem_valid drops.
  - Completion and timeout in the same cycle: completion wins.
- Latency, with mem_ready same-cycle and mem_resp_valid the cycle after acceptance:
  - Grant at cycle T.
  - mem_valid at T+1.
  - mem_resp_valid at T+2.
  - respN_valid at T+3.
  - Minimum 3 cycles grant-to-response.
- Requesters hold req fields until ready. Changes to req fields after grant have no effect on the transaction.
- Reset mid-transaction: abandons the transaction immediately. No response pulse is generated. A late mem_resp_valid after reset release is ignored (state is IDLE).
- resp0_valid and resp1_valid are never high together. At most one transaction is outstanding.

Test Plan:
- Single read, port 0: req0 addr=0x00000010 at T, mem_ready=1, mem_resp_valid at T+2 with rdata=0xDEADBEEF -> req0_ready at T, mem_valid/mem_addr=0x10 at T+1, resp0_valid with resp_rdata=0xDEADBEEF, resp_error=0 at T+3.
- Simultaneous requests after reset: both valid continuously, addr0=0x100, addr1=0x200 -> grant order 0,1,0,1 (mem_addr 0x100,0x200,0x100,0x200); never both ready.
- Write, port 1: req1_write=1, addr=0x40, wdata=0x12345678, mem_ready delayed 3 cycles -> mem_valid held with stable fields 4 cycles; resp1_valid pulse with resp_rdata=0.
- Timeout, TIMEOUT=4: mem_ready=1, mem_resp_valid never -> resp pulse with resp_error=1 five cycles after mem_valid first rises; error_sticky=1 until reset; next request served normally.
- Reset mid-WAIT: assert reset=0 during WAIT, release, then drive mem_resp_valid -> all outputs 0 during reset, no resp*_valid afterwards, busy=0.
- Back-to-back: new req0 valid on the cycle resp1_valid pulses -> req0_ready in that same cycle.
